// File: rtl/mem151_pkg.sv
// Shared definitions for the ext_mem_responder slice: FSM state codes, beat index width and LFSR constants.
// Bus-width macros (MEM_DATA_BITS, MEM_DATA_CYCLES, MEM_ADDR_BITS, MEM_TAG_BITS) default here if not set globally.
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif
`ifndef MEM_DATA_CYCLES
`define MEM_DATA_CYCLES 4
`endif
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 28
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 4
`endif

package mem151_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RD   = 2'd2;
    localparam logic [1:0] ST_WR   = 2'd3;

    localparam int BEAT_BITS  = $clog2(`MEM_DATA_CYCLES);
    localparam int DATA_BYTES = `MEM_DATA_BITS / 8;

    // Polynomial x^8+x^6+x^5+x^4+1 as a mask over the shift register bits 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ext_mem_array.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
// Read data appears the cycle after the address is presented; a same-address write returns the old word.
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif

module ext_mem_array
    import mem151_pkg::*;
#(
    parameter int ADDR_BITS = 12
) (
    input  logic                      clk,
    input  logic [ADDR_BITS-1:0]      addr,
    input  logic                      write_en,
    input  logic [DATA_BYTES-1:0]     byte_en,
    input  logic [`MEM_DATA_BITS-1:0] write_data,
    output logic [`MEM_DATA_BITS-1:0] read_data
);

    logic [`MEM_DATA_BITS-1:0] mem [0:(1 << ADDR_BITS)-1];

    always_ff @(posedge clk) begin
        if (write_en) begin
            for (int i = 0; i < DATA_BYTES; i++) begin
                if (byte_en[i]) begin
                    mem[addr][i*8 +: 8] <= write_data[i*8 +: 8];
                end
            end
        end
        read_data <= mem[addr];
    end

endmodule

// File: rtl/ext_mem_responder.sv
// Memory-side responder for the cache/arbiter request protocol: line writes under byte mask, tagged reads after LATENCY.
// Optional feature macro EXT_MEM_BACKPRESSURE_EN: LFSR-driven pseudo-random deassertion of the two ready outputs.
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif
`ifndef MEM_DATA_CYCLES
`define MEM_DATA_CYCLES 4
`endif
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 28
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 4
`endif

module ext_mem_responder
    import mem151_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          mem_req_valid,
    output logic                          mem_req_ready,
    input  logic                          mem_req_rw,
    input  logic [`MEM_ADDR_BITS-1:0]     mem_req_addr,
    input  logic [`MEM_TAG_BITS-1:0]      mem_req_tag,
    input  logic                          mem_req_data_valid,
    output logic                          mem_req_data_ready,
    input  logic [`MEM_DATA_BITS-1:0]     mem_req_data_bits,
    input  logic [`MEM_DATA_BITS/8-1:0]   mem_req_data_mask,
    output logic                          mem_resp_valid,
    output logic [`MEM_DATA_BITS-1:0]     mem_resp_data,
    output logic [`MEM_TAG_BITS-1:0]      mem_resp_tag
);

    localparam int RAM_ADDR_BITS = DEPTH_LOG2 + BEAT_BITS;
    localparam logic [BEAT_BITS-1:0] BEAT_LAST = BEAT_BITS'(`MEM_DATA_CYCLES - 1);
    // WAIT spans LATENCY-1 cycles because the RAM read adds the final cycle
    localparam logic [3:0] LAT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    logic [1:0]                state;
    logic [DEPTH_LOG2-1:0]     line;
    logic [`MEM_TAG_BITS-1:0]  tag;
    logic [BEAT_BITS-1:0]      beat;
    logic [BEAT_BITS-1:0]      beat_next;
    logic [3:0]                lat_cnt;
    logic [RAM_ADDR_BITS-1:0]  ram_addr;
    logic [`MEM_DATA_BITS-1:0] ram_rdata;
    logic                      idle_gate;
    logic                      wr_gate;
    logic                      req_fire;
    logic                      wr_fire;
    logic                      unused_addr;

    assign unused_addr = ^mem_req_addr[`MEM_ADDR_BITS-1:DEPTH_LOG2];

`ifdef EXT_MEM_BACKPRESSURE_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign idle_gate = ~lfsr[0];
    assign wr_gate   = ~lfsr[1];
`else
    assign idle_gate = 1'b1;
    assign wr_gate   = 1'b1;
`endif

    assign mem_req_ready      = !reset && (state == ST_IDLE) && idle_gate;
    assign mem_req_data_ready = !reset && (state == ST_WR) && wr_gate;
    assign mem_resp_valid     = !reset && (state == ST_RD);
    assign mem_resp_data      = reset ? '0 : ram_rdata;
    assign mem_resp_tag       = reset ? '0 : tag;

    assign req_fire  = mem_req_valid && mem_req_ready;
    assign wr_fire   = mem_req_data_valid && mem_req_data_ready;
    assign beat_next = beat + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            beat    <= '0;
            lat_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_fire) begin
                        line    <= mem_req_addr[DEPTH_LOG2-1:0];
                        tag     <= mem_req_tag;
                        beat    <= '0;
                        lat_cnt <= LAT_LOAD;
                        if (mem_req_rw) begin
                            state <= ST_WR;
                        end else if (LATENCY > 1) begin
                            state <= ST_WAIT;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        state <= ST_RD;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                ST_RD: begin
                    beat <= beat_next;
                    if (beat == BEAT_LAST) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    if (wr_fire) begin
                        beat <= beat_next;
                        if (beat == BEAT_LAST) begin
                            state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // RAM address runs one beat ahead of the response so registered read data lines up with RD
    always_comb begin
        ram_addr = {line, {BEAT_BITS{1'b0}}};
        case (state)
            ST_IDLE: ram_addr = {mem_req_addr[DEPTH_LOG2-1:0], {BEAT_BITS{1'b0}}};
            ST_RD:   ram_addr = {line, beat_next};
            ST_WR:   ram_addr = {line, beat};
            default: ram_addr = {line, {BEAT_BITS{1'b0}}};
        endcase
    end

    ext_mem_array #(
        .ADDR_BITS (RAM_ADDR_BITS)
    ) u_array (
        .clk        (clk),
        .addr       (ram_addr),
        .write_en   (wr_fire),
        .byte_en    (mem_req_data_mask),
        .write_data (mem_req_data_bits),
        .read_data  (ram_rdata)
    );

endmodule

// File: doc/ext_mem_responder.md
# ext_mem_responder

Synthesizable responder for the cache-to-main-memory request/response protocol; sits on the memory side of the arbiter in place of the external memory model. It accepts line-sized read and write requests and stores write data beats under a byte mask. For reads, it returns tagged data beats after a fixed latency. It is used for FPGA bring-up and as a cycle-exact bench target for cache and arbiter verification.

## Interface
- DEPTH_LOG2, 10: log2 of stored lines; total beats = 2^DEPTH_LOG2 × `MEM_DATA_CYCLES
- LATENCY, 4: cycles from request accept to first read beat; legal 1..15
- clk  in  1  clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- mem_req_valid  in  1  request present
- mem_req_ready  out  1  responder accepts request this cycle
- mem_req_rw  in  1  1 = write, 0 = read
- mem_req_addr  in  `MEM_ADDR_BITS  line address
- mem_req_tag  in  `MEM_TAG_BITS  tag echoed on read response
- mem_req_data_valid  in  1  write beat present
- mem_req_data_ready  out  1  responder accepts write beat
- mem_req_data_bits  in  `MEM_DATA_BITS  write beat
- mem_req_data_mask  in  `MEM_DATA_BITS/8  byte enables, bit i → byte i
- mem_resp_valid  out  1  read beat valid; no backpressure, initiator must sink
- mem_resp_data  out  `MEM_DATA_BITS  read beat
- mem_resp_tag  out  `MEM_TAG_BITS  tag of the owning request

## Operation
- States: IDLE, WAIT, RD, WR.
- IDLE: mem_req_ready=1. On valid&ready, capture addr[DEPTH_LOG2-1:0], tag, and rw. Upper addr bits are ignored, so addresses alias modulo 2^DEPTH_LOG2 lines. Clear the beat counter. Go to WR if rw=1; otherwise go to WAIT (LATENCY>1) or RD (LATENCY=1).
- WAIT: latency counter counts down; no outputs asserted; go to RD when expired.
- RD: emit `MEM_DATA_CYCLES beats on consecutive cycles, beat b = mem[{line,b}], tag = captured tag. Go to IDLE after the last beat.
- WR: mem_req_data_ready=1. Each data_valid&ready writes the masked bytes of beat b into mem[{line,b}] and increments b. Go to IDLE after beat `MEM_DATA_CYCLES-1. Idle cycles between beats are allowed.
- Only one request is outstanding at a time; mem_req_ready=0 outside IDLE.
- Data beats presented before the write request is accepted are not consumed.
- Beat counter width is log2(`MEM_DATA_CYCLES); it wraps to 0 on the final beat.
- Memory contents are unaffected by reset and are undefined until written.

## Timing
- Reset cycle: all outputs 0. The first cycle after reset deasserts is IDLE with mem_req_ready=1.
- Read accepted at cycle T: beats on cycles T+LATENCY … T+LATENCY+`MEM_DATA_CYCLES-1; mem_resp_valid is contiguous.
- Earliest next accept after a read: cycle T+LATENCY+`MEM_DATA_CYCLES.
- Write: the final beat accepted at cycle W is readable by a read accepted at W+1 or later.
- Reset mid-operation: remaining read beats are dropped; write beats already accepted stay in memory; state returns to IDLE.
- mem_resp_data/tag are don't-care while mem_resp_valid=0; the bench compares only on valid.

## Configuration
- EXT_MEM_BACKPRESSURE_EN defined:
  - An 8-bit LFSR (seed 8'hA5, taps x^8+x^6+x^5+x^4+1) advances every cycle and loads the seed on reset.
  - mem_req_ready = IDLE & ~lfsr[0]; mem_req_data_ready = WR & ~lfsr[1].
  - Read response timing is unchanged.
- Undefined: ready signals depend on state only, as above; no LFSR is instantiated.

## Structure
- Shared package mem151_pkg holds:
  - the state enum (IDLE/WAIT/RD/WR);
  - beat index width derived from `MEM_DATA_CYCLES;
  - the LFSR seed and tap constants.
- Sub-module ext_mem_array: single-port synchronous RAM, `MEM_DATA_BITS wide, with per-byte write enable. Read data is registered, one-cycle read, aligned so that the first beat meets the LATENCY rule.

## Test plan
- Reset, then write line 0x3 with beats 0x11…, 0x22…, 0x33…, 0x44… (mask all ones), then read line 0x3 with tag 5 → four contiguous beats in the same order, tag 5, first beat at accept+4.
- Write line 0x7 with all-ones data; rewrite it with mask 16'h0001 and data 0 → read returns the low byte 0x00 in every beat and all other bytes 0xFF.
- Write with data_valid gaps (1 idle cycle between each beat) → all four beats stored; mem_req_ready stays 0 until after the fourth beat.
- Read line 0x3 | (1<<DEPTH_LOG2) → returns line 0x3 data (aliasing).
- Assert reset during the second read beat → no further mem_resp_valid; mem_req_ready=1 one cycle after reset deasserts; a subsequent read of line 0x3 returns intact data.
- With EXT_MEM_BACKPRESSURE_EN: 200 random requests → ready never high outside IDLE/WR, memory scoreboard matches, and read latency is still exactly LATENCY.
